// File: rtl/axi_ram_responder_pkg.sv
// Shared AXI widths, burst length type and the responder FSM state encoding.
// The wait-state LFSR helpers are used only when AXI_RAM_WAIT_STATE_EN is defined.
package axi_ram_responder_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  typedef logic [7:0] axi_burst_len_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_BURST,
    WRITE_DATA,
    WRITE_RESP
  } axi_ram_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/axi_ram_responder_if.sv
// AXI4 subset used between the L2 axi_bus master port and the RAM responder.
// m_* are driven by the master, s_* by the responder.
interface axi4_interface;
  import axi_ram_responder_pkg::*;

  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  axi_burst_len_t            m_awlen;
  logic                      m_awvalid;
  logic                      s_awready;

  logic [AXI_DATA_WIDTH-1:0] m_wdata;
  logic                      m_wlast;
  logic                      m_wvalid;
  logic                      s_wready;

  logic                      s_bvalid;
  logic                      m_bready;

  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  axi_burst_len_t            m_arlen;
  logic                      m_arvalid;
  logic                      s_arready;

  logic [AXI_DATA_WIDTH-1:0] s_rdata;
  logic                      s_rlast;
  logic                      s_rvalid;
  logic                      m_rready;

  modport master (
    output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
           m_araddr, m_arlen, m_arvalid, m_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rlast, s_rvalid
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wlast, m_wvalid, m_bready,
           m_araddr, m_arlen, m_arvalid, m_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rdata, s_rlast, s_rvalid
  );

endinterface

// File: rtl/axi_ram_responder_sram.sv
// Simple dual-port RAM: one synchronous read port, one write port, no reset.
module axi_ram_responder_sram #(
  parameter  int DATA_WIDTH = 32,
  parameter  int SIZE       = 16384,
  localparam int AW         = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 RAM responder: one INCR burst at a time, alternating AR/AW grant on contention.
// Define AXI_RAM_WAIT_STATE_EN to insert LFSR-driven wait states on the ready/valid outputs.
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 16384
) (
  input  logic         clk,
  input  logic         reset,
  axi4_interface.slave axi_bus
);

  localparam int IW = $clog2(MEM_WORDS);

  axi_ram_state_t            state_q, state_d;
  logic [IW-1:0]             addr_q, addr_d, raddr;
  axi_burst_len_t            cnt_q, cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic                      prio_rd_q, prio_rd_d;
  logic                      arready, awready, wready, we;
  logic                      grant_rd, grant_wr, r_hs, w_hs, last_beat;
  logic                      stall, stall_nxt;
  logic [AXI_DATA_WIDTH-1:0] ram_q;
  logic [IW-1:0]             ar_idx, aw_idx;

  assign ar_idx = axi_bus.m_araddr[IW+1:2];
  assign aw_idx = axi_bus.m_awaddr[IW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_bus.m_araddr[AXI_ADDR_WIDTH-1:IW+2], axi_bus.m_araddr[1:0],
                              axi_bus.m_awaddr[AXI_ADDR_WIDTH-1:IW+2], axi_bus.m_awaddr[1:0]};

`ifdef AXI_RAM_WAIT_STATE_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  // stall_nxt lets s_rvalid be decided a cycle ahead, so a presented beat is never withdrawn
  assign stall     = lfsr_q[0];
  assign stall_nxt = lfsr_d[0];
`else
  assign stall     = 1'b0;
  assign stall_nxt = 1'b0;
`endif

  assign grant_rd  = axi_bus.m_arvalid && (!axi_bus.m_awvalid || prio_rd_q);
  assign grant_wr  = axi_bus.m_awvalid && !grant_rd;
  assign r_hs      = rvalid_q && axi_bus.m_rready;
  assign last_beat = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      prio_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q;
    prio_rd_d = prio_rd_q;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    w_hs      = 1'b0;
    we        = 1'b0;
    raddr     = addr_q;
    case (state_q)
      IDLE: begin
        arready = grant_rd && !stall;
        awready = grant_wr && !stall;
        raddr   = ar_idx;
        if (arready) begin
          addr_d    = ar_idx;
          cnt_d     = axi_bus.m_arlen;
          rvalid_d  = !stall_nxt;
          prio_rd_d = !prio_rd_q;
          state_d   = READ_BURST;
        end else if (awready) begin
          addr_d    = aw_idx;
          cnt_d     = axi_bus.m_awlen;
          prio_rd_d = !prio_rd_q;
          state_d   = WRITE_DATA;
        end
      end
      READ_BURST: begin
        // Look ahead one word on a handshake so the next beat follows without a bubble
        if (r_hs) begin
          if (last_beat) begin
            rvalid_d = 1'b0;
            state_d  = IDLE;
          end else begin
            addr_d   = addr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
            raddr    = addr_q + 1'b1;
            rvalid_d = !stall_nxt;
          end
        end else if (!rvalid_q) begin
          rvalid_d = !stall_nxt;
        end
      end
      WRITE_DATA: begin
        wready = !stall;
        w_hs   = wready && axi_bus.m_wvalid;
        we     = w_hs;
        if (w_hs) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (axi_bus.m_wlast || last_beat) state_d = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        if (axi_bus.m_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  axi_ram_responder_sram #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .SIZE       (MEM_WORDS)
  ) u_sram (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q),
    .wdata (axi_bus.m_wdata),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Address readies are combinational from m_*valid, so gate them with reset directly
  assign axi_bus.s_arready = reset && arready;
  assign axi_bus.s_awready = reset && awready;
  assign axi_bus.s_wready  = wready;
  assign axi_bus.s_bvalid  = (state_q == WRITE_RESP);
  assign axi_bus.s_rvalid  = rvalid_q;
  assign axi_bus.s_rlast   = rvalid_q && last_beat;
  assign axi_bus.s_rdata   = rvalid_q ? ram_q : '0;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed + random bench for axi_ram_responder against a word-array memory model.
// Also builds with AXI_RAM_WAIT_STATE_EN, adding checks that every stall matches lfsr[0].
module tb_axi_ram_responder;

  localparam int MW = 256;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi4_interface axi_bus();

  axi_ram_responder #(.MEM_WORDS(MW)) dut (
    .clk     (clk),
    .reset   (reset),
    .axi_bus (axi_bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [MW];
  bit          prio_rd = 1'b1;

`ifdef AXI_RAM_WAIT_STATE_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset)
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) |
                          (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 300;
`endif

  function automatic bit stall_now();
`ifdef AXI_RAM_WAIT_STATE_EN
    return m_lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stall_chk(input string tag);
`ifdef AXI_RAM_WAIT_STATE_EN
    check(tag, 32'(m_lfsr[0]), 32'd0);
`else
    if (tag.len() == 0) $display("empty stall tag");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for an address accept; the granted channel's valid is dropped after the edge
  task automatic addr_wait(output bit got_rd);
    int t = 0;
    bit exp_rd;
    #1;
    while (!(axi_bus.s_arready || axi_bus.s_awready) && t < 200) begin
      tick(); #1; t++;
    end
    check("addr_accept", 32'(axi_bus.s_arready || axi_bus.s_awready), 32'd1);
    exp_rd = axi_bus.m_arvalid && (!axi_bus.m_awvalid || prio_rd);
    check("grant", {30'd0, axi_bus.s_arready, axi_bus.s_awready}, exp_rd ? 32'd2 : 32'd1);
    stall_chk("addr_lfsr");
    got_rd = axi_bus.s_arready;
    tick();
    prio_rd = !prio_rd;
    if (got_rd) axi_bus.m_arvalid = 1'b0;
    else        axi_bus.m_awvalid = 1'b0;
  endtask

  task automatic r_phase(input logic [31:0] addr, input int len, input int mode);
    int idx0 = int'((addr >> 2) % MW);
    int beat = 0, t = 0;
    bit prev_stall = 1'b0;
    logic [31:0] pd;
    logic pl;
    while (beat <= len && t < 2000) begin
      case (mode)
        0:       axi_bus.m_rready = 1'b1;
        1:       axi_bus.m_rready = (t % 4 == 0) || (t % 4 == 3);
        default: axi_bus.m_rready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall) check("r_hold_valid", 32'(axi_bus.s_rvalid), 32'd1);
      if (axi_bus.s_rvalid) begin
        if (prev_stall) begin
          check("r_hold_data", axi_bus.s_rdata, pd);
          check("r_hold_last", 32'(axi_bus.s_rlast), 32'(pl));
        end else begin
          stall_chk("r_lfsr");
        end
        if (axi_bus.m_rready) begin
          check("rdata", axi_bus.s_rdata, ref_mem[(idx0 + beat) % MW]);
          check("rlast", 32'(axi_bus.s_rlast), 32'(beat == len));
          beat++;
        end
        prev_stall = !axi_bus.m_rready;
        pd = axi_bus.s_rdata;
        pl = axi_bus.s_rlast;
      end else begin
        prev_stall = 1'b0;
      end
      tick(); t++;
    end
    axi_bus.m_rready = 1'b0;
    check("r_beats", 32'(beat), 32'(len + 1));
`ifndef AXI_RAM_WAIT_STATE_EN
    if (mode == 0) check("r_full_rate", 32'(t), 32'(len + 1));
`endif
    #1;
    check("r_end_valid", 32'(axi_bus.s_rvalid), 32'd0);
  endtask

  // dbase < 0 gives random data, else beat b carries dbase+b; stop >= 0 abandons after that many beats
  task automatic w_phase(input logic [31:0] addr, input int len, input int wlast_at,
                         input int dbase, input int bdelay, input int stop);
    int idx0 = int'((addr >> 2) % MW);
    int nb = ((wlast_at < len) ? wlast_at : len) + 1;
    int b = 0, t = 0;
    logic [31:0] d;
    d = (dbase < 0) ? $urandom : 32'(dbase);
    while (b < nb && t < 2000) begin
      if (stop >= 0 && b == stop) begin
        axi_bus.m_wvalid = 1'b0;
        return;
      end
      axi_bus.m_wvalid = 1'b1;
      axi_bus.m_wdata  = d;
      axi_bus.m_wlast  = (b == wlast_at);
      #1;
      if (axi_bus.s_wready) begin
        stall_chk("w_lfsr");
        ref_mem[(idx0 + b) % MW] = d;
        b++;
        d = (dbase < 0) ? $urandom : 32'(dbase + b);
      end
      tick(); t++;
    end
    check("w_beats", 32'(b), 32'(nb));
    axi_bus.m_wvalid = 1'b1;
    axi_bus.m_wlast  = 1'b0;
    axi_bus.m_wdata  = 32'hDEAD_BEEF;
    axi_bus.m_bready = (bdelay == 0);
    #1;
    check("w_extra_refused", 32'(axi_bus.s_wready), 32'd0);
    check("b_latency", 32'(axi_bus.s_bvalid), 32'd1);
    tick();
    axi_bus.m_wvalid = 1'b0;
    for (int i = 0; i < bdelay; i++) begin
      if (i == bdelay - 1) axi_bus.m_bready = 1'b1;
      #1;
      check("b_hold", 32'(axi_bus.s_bvalid), 32'd1);
      tick();
    end
    axi_bus.m_bready = 1'b1;
    #1;
    check("b_done", 32'(axi_bus.s_bvalid), 32'd0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int len, input int wlast_at,
                             input int dbase, input int bdelay, input int stop);
    bit g;
    axi_bus.m_awaddr  = addr;
    axi_bus.m_awlen   = 8'(len);
    axi_bus.m_awvalid = 1'b1;
    addr_wait(g);
    w_phase(addr, len, wlast_at, dbase, bdelay, stop);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int len, input int mode);
    bit g;
    axi_bus.m_araddr  = addr;
    axi_bus.m_arlen   = 8'(len);
    axi_bus.m_arvalid = 1'b1;
    addr_wait(g);
    r_phase(addr, len, mode);
  endtask

  task automatic dual(input logic [31:0] ra, input int rl, input logic [31:0] wa, input int wl);
    bit g;
    axi_bus.m_araddr  = ra;
    axi_bus.m_arlen   = 8'(rl);
    axi_bus.m_arvalid = 1'b1;
    axi_bus.m_awaddr  = wa;
    axi_bus.m_awlen   = 8'(wl);
    axi_bus.m_awvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      addr_wait(g);
      if (g) r_phase(ra, rl, 0);
      else   w_phase(wa, wl, wl, -1, 0, -1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_arready"}, 32'(axi_bus.s_arready), 32'd0);
    check({tag, "_awready"}, 32'(axi_bus.s_awready), 32'd0);
    check({tag, "_wready"},  32'(axi_bus.s_wready),  32'd0);
    check({tag, "_bvalid"},  32'(axi_bus.s_bvalid),  32'd0);
    check({tag, "_rvalid"},  32'(axi_bus.s_rvalid),  32'd0);
    check({tag, "_rlast"},   32'(axi_bus.s_rlast),   32'd0);
    check({tag, "_rdata"},   axi_bus.s_rdata,        32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    int len, wl;
    logic [31:0] a;
    reset = 1'b0;
    axi_bus.m_awaddr = '0; axi_bus.m_awlen = '0; axi_bus.m_awvalid = 1'b0;
    axi_bus.m_wdata  = '0; axi_bus.m_wlast = 1'b0; axi_bus.m_wvalid = 1'b0;
    axi_bus.m_bready = 1'b1;
    axi_bus.m_araddr = '0; axi_bus.m_arlen = '0; axi_bus.m_arvalid = 1'b1;
    axi_bus.m_rready = 1'b0;

    // Reset state, then s_arready follows m_arvalid once released
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_arready_follow", 32'(axi_bus.s_arready), 32'(!stall_now()));
    axi_bus.m_arvalid = 1'b0;
    #1;
    check("rel_arready_drop", 32'(axi_bus.s_arready), 32'd0);
    tick();

    // 16-beat write then full-rate read back; B held two cycles
    write_burst(32'h100, 15, 15, 0, 2, -1);
    read_burst(32'h100, 15, 0);

    // Read with m_rready pattern 1,0,0,1
    read_burst(32'h100, 15, 1);

    // Wrap at the top of the RAM and alias from address MEM_WORDS*4
    write_burst(32'((MW - 2) * 4), 3, 3, 32'hA000, 0, -1);
    read_burst(32'((MW - 2) * 4), 3, 0);
    read_burst(32'(MW * 4), 0, 0);

    // Reset while a read beat is stalled
    axi_bus.m_araddr = 32'h100; axi_bus.m_arlen = 8'd7; axi_bus.m_arvalid = 1'b1;
    addr_wait(g);
    tick(); tick();
    #2;
    axi_bus.m_arvalid = 1'b1;
    reset = 1'b0;
    #1;
    check_all_zero("midrd");
    @(negedge clk);
    reset = 1'b1;
    axi_bus.m_arvalid = 1'b0;
    prio_rd = 1'b1;
    tick();

    // Reset after three of eight write beats; accepted beats must survive
    write_burst(32'h280, 7, 7, 32'h5000, 0, 3);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midwr");
    @(negedge clk);
    reset = 1'b1;
    prio_rd = 1'b1;
    tick();
    read_burst(32'h280, 2, 0);

    // Simultaneous AR/AW twice; priority starts at read after reset
    dual(32'h100, 3, 32'h300, 3);
    dual(32'h300, 3, 32'h104, 5);
    read_burst(32'h100, 15, 2);

    // Early m_wlast, then a burst whose length ends before any m_wlast
    write_burst(32'h200, 7, 3, 32'h7000, 0, -1);
    read_burst(32'h200, 3, 0);
    write_burst(32'h240, 1, 255, 32'h7100, 1, -1);
    read_burst(32'h240, 1, 0);

    // Fill the whole RAM, then random bursts against the model
    write_burst(32'h0, 255, 255, -1, 0, -1);
    for (int k = 0; k < N_RAND; k++) begin
      a   = $urandom;
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       wl = int'($urandom_range(0, len));
          1:       wl = 255;
          default: wl = len;
        endcase
        write_burst(a, len, wl, -1, int'($urandom_range(0, 1)), -1);
      end else begin
        read_burst(a, len, int'($urandom_range(0, 2)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
